alu_ctrl_branch: RTL and testbench
==================================

ALU_CTRL_BRANCH -- requirements
Module: alu_ctrl_branch

Interface
REQ-001 Parameter: DATA_W, 16, datapath/instruction width; only 16 is supported.
REQ-002 clk  input  1  sole clock; flag register updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-high (asserted = 1), despite the _n suffix.
REQ-004 instr  input  16  current instruction word.
REQ-005 pc  input  16  address of instr.
REQ-006 op_a  input  16  register-file value addressed by rs.
REQ-007 op_b  input  16  register-file value addressed by rt.
REQ-008 rs, rt, rd  output  4 each  decoded register selects.
REQ-009 result  output  16  ALU result / memory address / link value.
REQ-010 reg_we, mem_we, mem_re, halt  output  1 each  decoded controls.
REQ-011 call, ret, take_br  output  1 each  redirect requests.
REQ-012 target  output  16  redirect address, valid when call|ret|take_br.
REQ-013 z, n, v  output  1 each  registered condition flags.

Function
REQ-014 Opcode = instr[15:12]: 0 ADD, 1 PADDSB, 2 SUB, 3 AND, 4 NOR, 5 SLL, 6 SRL, 7 SRA, 8 LW, 9 SW, A LHB, B LLB, C B, D CALL, E RET, F HLT.
REQ-015 Fields: rd=instr[11:8], rs=instr[7:4], rt=instr[3:0]; for SW and LHB, rt=instr[11:8]; for RET, rs=15; for CALL, rd=15; unused selects are 0.
REQ-016 ADD/SUB: signed 16-bit, saturating to 0x7FFF on positive overflow and 0x8000 on negative overflow.
REQ-017 PADDSB: two independent signed byte adds, each saturating to 0x7F/0x80.
REQ-018 AND: op_a & op_b; NOR: ~(op_a | op_b).
REQ-019 SLL/SRL/SRA: op_a shifted by instr[3:0] (0..15); SRA sign-fills.
REQ-020 LW/SW: result = op_a + sign-extended instr[3:0]; wraps mod 2^16.
REQ-021 LHB: result = {instr[7:0], op_b[7:0]}; LLB: result = sign-extended instr[7:0].
REQ-022 CALL: result = pc+1 (link); target = pc+1+sext(instr[11:0]).
REQ-023 RET: target = op_a.
REQ-024 B: cond = instr[11:9]; target = pc+1+sext(instr[8:0]); take_br per REQ-025 using registered z/n/v.
REQ-025 Conditions: 000 !z; 001 z; 010 !z&!n; 011 n; 100 z|!n; 101 n|z; 110 v; 111 always.
REQ-026 reg_we = 1 for opcodes 0-8, A, B, D; mem_re = 1 for LW only; mem_we = 1 for SW only.
REQ-027 call = 1 for CALL, ret = 1 for RET, halt = 1 for HLT; all redirect outputs 0 otherwise.
REQ-028 All outputs except z/n/v are combinational from current inputs.
REQ-029 Flag update at clk edge: ADD/SUB write z (result==0), n (result[15]), v (overflow, before saturation); AND/NOR/SLL/SRL/SRA write z only; all other opcodes hold flags.
REQ-030 Branch in the cycle after a flag-setting op sees the updated flags; a branch in the same cycle sees pre-update flags.
REQ-031 When halt is 1, flags hold regardless of opcode.

Reset
REQ-032 While rst_n=1: z=n=v=0 immediately (asynchronous); combinational outputs still follow inputs.
REQ-033 Reset asserted mid-operation discards any pending flag update; first edge after release updates normally.

Verification
REQ-034 ADD op_a=0x7FFF, op_b=0x0001 -> result=0x7FFF; next cycle v=1, n=0, z=0.
REQ-035 SUB op_a=op_b=0x1234, then B cond=001 imm9=0x1FE at pc=0x0010 -> take_br=1, target=0x000F.
REQ-036 PADDSB op_a=0x7F80, op_b=0x0180 -> result=0x7F80; flags unchanged.
REQ-037 CALL instr=0xD005, pc=0x0100 -> call=1, rd=15, reg_we=1, result=0x0101, target=0x0106.
REQ-038 SRA op_a=0x8000 shamt=15 -> result=0xFFFF; LLB imm=0x80 -> result=0xFF80.
REQ-039 Set v=1 via overflow, assert rst_n=1 between edges -> z=n=v=0 at once; B cond=110 -> take_br=0.

Source files
------------

// File: rtl/alu_ctrl_branch.sv
// ALU, instruction decode and branch resolution for a 16-bit single-issue core.
// Everything is combinational from the current instruction except the z/n/v flags.
module alu_ctrl_branch #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic [3:0]        rd,
  output logic [DATA_W-1:0] result,
  output logic              reg_we,
  output logic              mem_we,
  output logic              mem_re,
  output logic              halt,
  output logic              call,
  output logic              ret,
  output logic              take_br,
  output logic [DATA_W-1:0] target,
  output logic              z,
  output logic              n,
  output logic              v
);

  localparam int unsigned MSB    = DATA_W - 1;
  localparam int unsigned HALF_W = DATA_W / 2;
  localparam logic [DATA_W-1:0] W_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] W_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [HALF_W-1:0] B_POS = {1'b0, {(HALF_W-1){1'b1}}};
  localparam logic [HALF_W-1:0] B_NEG = {1'b1, {(HALF_W-1){1'b0}}};

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_PADDSB = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_NOR = 4'h4, OP_SLL    = 4'h5, OP_SRL = 4'h6, OP_SRA = 4'h7,
    OP_LW  = 4'h8, OP_SW     = 4'h9, OP_LHB = 4'hA, OP_LLB = 4'hB,
    OP_B   = 4'hC, OP_CALL   = 4'hD, OP_RET = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  opcode_e opcode;
  logic z_q, n_q, v_q, z_d, n_d, v_d;
  logic [DATA_W-1:0] sum_raw, dif_raw, add_sat, sub_sat;
  logic              add_ovf, sub_ovf;
  logic [HALF_W-1:0] hi_sum, lo_sum, hi_sat, lo_sat;
  logic              hi_ovf, lo_ovf;
  logic [DATA_W-1:0] imm4, imm8, imm9, imm12, pc_inc;
  logic              cond_met;

  assign opcode = opcode_e'(instr[15:12]);

  // Word add/sub with saturation; overflow direction follows op_a's sign
  assign sum_raw = op_a + op_b;
  assign dif_raw = op_a - op_b;
  assign add_ovf = (op_a[MSB] == op_b[MSB]) && (sum_raw[MSB] != op_a[MSB]);
  assign sub_ovf = (op_a[MSB] != op_b[MSB]) && (dif_raw[MSB] != op_a[MSB]);
  assign add_sat = add_ovf ? (op_a[MSB] ? W_NEG : W_POS) : sum_raw;
  assign sub_sat = sub_ovf ? (op_a[MSB] ? W_NEG : W_POS) : dif_raw;

  // Independent saturating byte lanes for PADDSB
  assign hi_sum = op_a[DATA_W-1:HALF_W] + op_b[DATA_W-1:HALF_W];
  assign lo_sum = op_a[HALF_W-1:0] + op_b[HALF_W-1:0];
  assign hi_ovf = (op_a[MSB] == op_b[MSB]) && (hi_sum[HALF_W-1] != op_a[MSB]);
  assign lo_ovf = (op_a[HALF_W-1] == op_b[HALF_W-1]) && (lo_sum[HALF_W-1] != op_a[HALF_W-1]);
  assign hi_sat = hi_ovf ? (op_a[MSB] ? B_NEG : B_POS) : hi_sum;
  assign lo_sat = lo_ovf ? (op_a[HALF_W-1] ? B_NEG : B_POS) : lo_sum;

  // Sign-extended immediates and link address
  assign imm4   = {{(DATA_W-4){instr[3]}}, instr[3:0]};
  assign imm8   = {{(DATA_W-8){instr[7]}}, instr[7:0]};
  assign imm9   = {{(DATA_W-9){instr[8]}}, instr[8:0]};
  assign imm12  = {{(DATA_W-12){instr[11]}}, instr[11:0]};
  assign pc_inc = pc + DATA_W'(1);

  // Branch condition evaluated against the registered flags
  always_comb begin
    cond_met = 1'b0;
    case (instr[11:9])
      3'b000:  cond_met = !z_q;
      3'b001:  cond_met = z_q;
      3'b010:  cond_met = !z_q && !n_q;
      3'b011:  cond_met = n_q;
      3'b100:  cond_met = z_q || !n_q;
      3'b101:  cond_met = n_q || z_q;
      3'b110:  cond_met = v_q;
      default: cond_met = 1'b1;
    endcase
  end

  // Decode, datapath result and redirect generation
  always_comb begin
    rs      = 4'd0;
    rt      = 4'd0;
    rd      = 4'd0;
    result  = '0;
    target  = '0;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    halt    = 1'b0;
    call    = 1'b0;
    ret     = 1'b0;
    take_br = 1'b0;
    case (opcode)
      OP_ADD, OP_PADDSB, OP_SUB, OP_AND, OP_NOR: begin
        rd     = instr[11:8];
        rs     = instr[7:4];
        rt     = instr[3:0];
        reg_we = 1'b1;
        case (opcode)
          OP_ADD:    result = add_sat;
          OP_PADDSB: result = {hi_sat, lo_sat};
          OP_SUB:    result = sub_sat;
          OP_AND:    result = op_a & op_b;
          default:   result = ~(op_a | op_b);
        endcase
      end
      OP_SLL, OP_SRL, OP_SRA: begin
        rd     = instr[11:8];
        rs     = instr[7:4];
        reg_we = 1'b1;
        case (opcode)
          OP_SLL:  result = op_a << instr[3:0];
          OP_SRL:  result = op_a >> instr[3:0];
          default: result = DATA_W'($signed(op_a) >>> instr[3:0]);
        endcase
      end
      OP_LW: begin
        rd     = instr[11:8];
        rs     = instr[7:4];
        result = op_a + imm4;
        reg_we = 1'b1;
        mem_re = 1'b1;
      end
      OP_SW: begin
        rt     = instr[11:8];
        rs     = instr[7:4];
        result = op_a + imm4;
        mem_we = 1'b1;
      end
      OP_LHB: begin
        rd     = instr[11:8];
        rt     = instr[11:8];
        result = {instr[7:0], op_b[7:0]};
        reg_we = 1'b1;
      end
      OP_LLB: begin
        rd     = instr[11:8];
        result = imm8;
        reg_we = 1'b1;
      end
      OP_B: begin
        target  = pc_inc + imm9;
        take_br = cond_met;
      end
      OP_CALL: begin
        rd     = 4'd15;
        result = pc_inc;
        target = pc_inc + imm12;
        reg_we = 1'b1;
        call   = 1'b1;
      end
      OP_RET: begin
        rs     = 4'd15;
        target = op_a;
        ret    = 1'b1;
      end
      default: halt = 1'b1;
    endcase
  end

  // Next-flag selection: arithmetic writes z/n/v, logic and shifts write z only
  always_comb begin
    z_d = z_q;
    n_d = n_q;
    v_d = v_q;
    if (!halt) begin
      case (opcode)
        OP_ADD: begin
          z_d = (result == '0);
          n_d = result[MSB];
          v_d = add_ovf;
        end
        OP_SUB: begin
          z_d = (result == '0);
          n_d = result[MSB];
          v_d = sub_ovf;
        end
        OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA: z_d = (result == '0);
        default: ;
      endcase
    end
  end

  // Flag register; reset input is active-high despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      z_q <= z_d;
      n_q <= n_d;
      v_q <= v_d;
    end
  end

  assign z = z_q;
  assign n = n_q;
  assign v = v_q;

endmodule

// File: tb/tb_alu_ctrl_branch.sv
// Scoreboard bench for alu_ctrl_branch: a behavioural model pushes expected
// outputs and next flags when an instruction is driven; the tests pop and compare.
module tb_alu_ctrl_branch;

  typedef struct packed {
    logic [15:0] result;
    logic [15:0] target;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [3:0]  rd;
    logic        reg_we;
    logic        mem_we;
    logic        mem_re;
    logic        halt;
    logic        call;
    logic        ret;
    logic        take_br;
  } comb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr, pc, op_a, op_b;
  logic [3:0]  rs, rt, rd;
  logic [15:0] result, target;
  logic        reg_we, mem_we, mem_re, halt, call, ret, take_br, z, n, v;

  comb_t       exp_q[$];
  logic [2:0]  flag_q[$];
  logic [2:0]  mflags;
  int          checks = 0;
  int          errors = 0;

  alu_ctrl_branch #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst), .instr(instr), .pc(pc), .op_a(op_a), .op_b(op_b),
    .rs(rs), .rt(rt), .rd(rd), .result(result), .reg_we(reg_we), .mem_we(mem_we),
    .mem_re(mem_re), .halt(halt), .call(call), .ret(ret), .take_br(take_br),
    .target(target), .z(z), .n(n), .v(v)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] sat16(input int s);
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return 16'(s);
  endfunction

  function automatic logic [7:0] sat8(input int s);
    if (s > 127) return 8'h7F;
    if (s < -128) return 8'h80;
    return 8'(s);
  endfunction

  function automatic comb_t model_comb(input logic [15:0] i, p, a, b, input logic [2:0] f);
    comb_t e;
    int    sh;
    logic  c;
    e  = '0;
    sh = int'(i[3:0]);
    case (i[15:12])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
        e.rd = i[11:8]; e.rs = i[7:4]; e.rt = i[3:0]; e.reg_we = 1'b1;
        case (i[15:12])
          4'h0: e.result = sat16(int'($signed(a)) + int'($signed(b)));
          4'h1: e.result = {sat8(int'($signed(a[15:8])) + int'($signed(b[15:8]))),
                            sat8(int'($signed(a[7:0])) + int'($signed(b[7:0])))};
          4'h2: e.result = sat16(int'($signed(a)) - int'($signed(b)));
          4'h3: e.result = a & b;
          default: e.result = ~(a | b);
        endcase
      end
      4'h5: begin e.rd = i[11:8]; e.rs = i[7:4]; e.reg_we = 1'b1; e.result = a << sh; end
      4'h6: begin e.rd = i[11:8]; e.rs = i[7:4]; e.reg_we = 1'b1; e.result = a >> sh; end
      4'h7: begin e.rd = i[11:8]; e.rs = i[7:4]; e.reg_we = 1'b1; e.result = 16'($signed(a) >>> sh); end
      4'h8: begin
        e.rd = i[11:8]; e.rs = i[7:4]; e.reg_we = 1'b1; e.mem_re = 1'b1;
        e.result = 16'(int'(a) + int'($signed(i[3:0])));
      end
      4'h9: begin
        e.rt = i[11:8]; e.rs = i[7:4]; e.mem_we = 1'b1;
        e.result = 16'(int'(a) + int'($signed(i[3:0])));
      end
      4'hA: begin e.rd = i[11:8]; e.rt = i[11:8]; e.reg_we = 1'b1; e.result = {i[7:0], b[7:0]}; end
      4'hB: begin e.rd = i[11:8]; e.reg_we = 1'b1; e.result = 16'(int'($signed(i[7:0]))); end
      4'hC: begin
        e.target = 16'(int'(p) + 1 + int'($signed(i[8:0])));
        case (i[11:9])
          3'd0: c = !f[2];
          3'd1: c = f[2];
          3'd2: c = !f[2] && !f[1];
          3'd3: c = f[1];
          3'd4: c = f[2] || !f[1];
          3'd5: c = f[1] || f[2];
          3'd6: c = f[0];
          default: c = 1'b1;
        endcase
        e.take_br = c;
      end
      4'hD: begin
        e.rd = 4'd15; e.reg_we = 1'b1; e.call = 1'b1;
        e.result = 16'(int'(p) + 1);
        e.target = 16'(int'(p) + 1 + int'($signed(i[11:0])));
      end
      4'hE: begin e.rs = 4'd15; e.ret = 1'b1; e.target = a; end
      default: e.halt = 1'b1;
    endcase
    return e;
  endfunction

  // Flags as {z,n,v}
  function automatic logic [2:0] model_flags(input logic [15:0] i, a, b, input logic [2:0] f);
    logic [15:0] r;
    int          s;
    r = model_comb(i, 16'h0000, a, b, f).result;
    case (i[15:12])
      4'h0: begin s = int'($signed(a)) + int'($signed(b)); return {r == 16'h0, r[15], (s > 32767) || (s < -32768)}; end
      4'h2: begin s = int'($signed(a)) - int'($signed(b)); return {r == 16'h0, r[15], (s > 32767) || (s < -32768)}; end
      4'h3, 4'h4, 4'h5, 4'h6, 4'h7: return {r == 16'h0, f[1], f[0]};
      default: return f;
    endcase
  endfunction

  function automatic comb_t observe();
    comb_t o;
    o.result = result; o.target = target; o.rs = rs; o.rt = rt; o.rd = rd;
    o.reg_we = reg_we; o.mem_we = mem_we; o.mem_re = mem_re; o.halt = halt;
    o.call = call; o.ret = ret; o.take_br = take_br;
    return o;
  endfunction

  // Apply one instruction and push its expected outputs and post-edge flags
  task automatic drive(input logic [15:0] i, p, a, b);
    instr = i; pc = p; op_a = a; op_b = b;
    exp_q.push_back(model_comb(i, p, a, b, mflags));
    flag_q.push_back(rst ? 3'b000 : model_flags(i, a, b, mflags));
  endtask

  task automatic test_reset();
    comb_t e;
    logic [2:0] f;
    rst = 1'b1;
    #1;
    checks++;
    if ({z, n, v} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {z, n, v}); end
    drive(16'h0123, 16'h0000, 16'h7FFF, 16'h0001);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (observe() !== e) begin errors++; $display("FAIL reset_comb got %h want %h", observe(), e); end
    @(posedge clk); #1;
    f = flag_q.pop_front(); mflags = f;
    checks++;
    if ({z, n, v} !== 3'b000) begin errors++; $display("FAIL reset_hold_flags got %b want 000", {z, n, v}); end
    rst = 1'b0;
  endtask

  task automatic test_add_sub_sat();
    logic [15:0] t_i [5] = '{16'h0123, 16'h0123, 16'h0123, 16'h2123, 16'h2123};
    logic [15:0] t_a [5] = '{16'h7FFF, 16'h8000, 16'h1234, 16'h8000, 16'h7FFF};
    logic [15:0] t_b [5] = '{16'h0001, 16'hFFFF, 16'h4321, 16'h0001, 16'hFFFF};
    comb_t e;
    logic [2:0] f;
    for (int k = 0; k < 5; k++) begin
      drive(t_i[k], 16'h0000, t_a[k], t_b[k]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (observe() !== e) begin errors++; $display("FAIL add_sub[%0d] got %h want %h", k, observe(), e); end
      if (k == 0) begin
        checks++;
        if (result !== 16'h7FFF) begin errors++; $display("FAIL add_pos_sat result got %h want 7fff", result); end
      end
      @(posedge clk); #1;
      f = flag_q.pop_front(); mflags = f;
      checks++;
      if ({z, n, v} !== f) begin errors++; $display("FAIL add_sub_flags[%0d] got %b want %b", k, {z, n, v}, f); end
      if (k == 0) begin
        checks++;
        if ({z, n, v} !== 3'b001) begin errors++; $display("FAIL add_ovf_flags got %b want 001", {z, n, v}); end
      end
    end
  endtask

  task automatic test_sub_branch();
    comb_t e;
    logic [2:0] f;
    drive(16'h2123, 16'h0000, 16'h1234, 16'h1234);
    #2; e = exp_q.pop_front(); checks++;
    if (observe() !== e) begin errors++; $display("FAIL sub_eq got %h want %h", observe(), e); end
    @(posedge clk); #1; f = flag_q.pop_front(); mflags = f; checks++;
    if ({z, n, v} !== 3'b100) begin errors++; $display("FAIL sub_eq_flags got %b want 100", {z, n, v}); end
    drive(16'hC3FE, 16'h0010, 16'h0000, 16'h0000);
    #2; e = exp_q.pop_front(); checks++;
    if (observe() !== e) begin errors++; $display("FAIL beq got %h want %h", observe(), e); end
    checks++;
    if (take_br !== 1'b1 || target !== 16'h000F) begin
      errors++; $display("FAIL beq_target got take=%b tgt=%h want take=1 tgt=000f", take_br, target);
    end
    @(posedge clk); #1; f = flag_q.pop_front(); mflags = f;
  endtask

  task automatic test_ops();
    logic [15:0] t_i [10] = '{16'h1000, 16'h700F, 16'hB180, 16'h5104, 16'h6203,
                              16'hA2AB, 16'h812F, 16'h9340, 16'h3456, 16'h4456};
    logic [15:0] t_a [10] = '{16'h7F80, 16'h8000, 16'h0000, 16'h8421, 16'h8421,
                              16'h0000, 16'h0000, 16'h1000, 16'hF0F0, 16'hF0F0};
    logic [15:0] t_b [10] = '{16'h0180, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                              16'h12CD, 16'h0000, 16'h0000, 16'h0F0F, 16'h0F0F};
    logic [15:0] t_r [10] = '{16'h7F80, 16'hFFFF, 16'hFF80, 16'h4210, 16'h1084,
                              16'hABCD, 16'hFFFF, 16'h1000, 16'h0000, 16'h0000};
    comb_t e;
    logic [2:0] f;
    for (int k = 0; k < 10; k++) begin
      drive(t_i[k], 16'h0000, t_a[k], t_b[k]);
      #2; e = exp_q.pop_front(); checks++;
      if (observe() !== e) begin errors++; $display("FAIL ops[%0d] got %h want %h", k, observe(), e); end
      checks++;
      if (result !== t_r[k]) begin errors++; $display("FAIL ops_result[%0d] got %h want %h", k, result, t_r[k]); end
      @(posedge clk); #1; f = flag_q.pop_front(); mflags = f; checks++;
      if ({z, n, v} !== f) begin errors++; $display("FAIL ops_flags[%0d] got %b want %b", k, {z, n, v}, f); end
    end
  endtask

  task automatic test_call_ret();
    comb_t e;
    logic [2:0] f;
    drive(16'hD005, 16'h0100, 16'h0000, 16'h0000);
    #2; e = exp_q.pop_front(); checks++;
    if (observe() !== e) begin errors++; $display("FAIL call got %h want %h", observe(), e); end
    checks++;
    if ({call, rd, reg_we, result, target} !== {1'b1, 4'd15, 1'b1, 16'h0101, 16'h0106}) begin
      errors++; $display("FAIL call_fields got call=%b rd=%h we=%b res=%h tgt=%h want 1 f 1 0101 0106",
                         call, rd, reg_we, result, target);
    end
    @(posedge clk); #1; f = flag_q.pop_front(); mflags = f;
    drive(16'hE000, 16'h0200, 16'hBEEF, 16'h0000);
    #2; e = exp_q.pop_front(); checks++;
    if (observe() !== e) begin errors++; $display("FAIL ret got %h want %h", observe(), e); end
    checks++;
    if ({ret, rs, target} !== {1'b1, 4'd15, 16'hBEEF}) begin
      errors++; $display("FAIL ret_fields got ret=%b rs=%h tgt=%h want 1 f beef", ret, rs, target);
    end
    @(posedge clk); #1; f = flag_q.pop_front(); mflags = f;
  endtask

  task automatic test_branch_conds();
    logic [15:0] s_i [5] = '{16'h2123, 16'h2123, 16'h0123, 16'h0123, 16'h2123};
    logic [15:0] s_a [5] = '{16'h1234, 16'h0001, 16'h0001, 16'h7FFF, 16'h8000};
    logic [15:0] s_b [5] = '{16'h1234, 16'h0002, 16'h0001, 16'h0001, 16'h0001};
    comb_t e;
    logic [2:0] f;
    logic [15:0] bi;
    for (int s = 0; s < 5; s++) begin
      drive(s_i[s], 16'h0000, s_a[s], s_b[s]);
      #2; void'(exp_q.pop_front());
      @(posedge clk); #1; f = flag_q.pop_front(); mflags = f; checks++;
      if ({z, n, v} !== f) begin errors++; $display("FAIL setup_flags[%0d] got %b want %b", s, {z, n, v}, f); end
      for (int c = 0; c < 8; c++) begin
        bi = {4'hC, 3'(c), 9'($urandom_range(511))};
        drive(bi, 16'($urandom), 16'h0000, 16'h0000);
        #2; e = exp_q.pop_front(); checks++;
        if (observe() !== e) begin errors++; $display("FAIL branch[%0d][%0d] got %h want %h", s, c, observe(), e); end
        @(posedge clk); #1; f = flag_q.pop_front(); mflags = f;
      end
    end
  endtask

  task automatic test_halt();
    comb_t e;
    logic [2:0] f;
    drive(16'h2123, 16'h0000, 16'h0001, 16'h0002);
    #2; void'(exp_q.pop_front());
    @(posedge clk); #1; f = flag_q.pop_front(); mflags = f;
    drive(16'hF123, 16'h0000, 16'h0000, 16'h0000);
    #2; e = exp_q.pop_front(); checks++;
    if (observe() !== e || halt !== 1'b1) begin errors++; $display("FAIL halt got %h want %h", observe(), e); end
    @(posedge clk); #1; f = flag_q.pop_front(); mflags = f; checks++;
    if ({z, n, v} !== 3'b010) begin errors++; $display("FAIL halt_flags got %b want 010", {z, n, v}); end
  endtask

  task automatic test_reset_mid();
    comb_t e;
    logic [2:0] f;
    drive(16'h0123, 16'h0000, 16'h7FFF, 16'h0001);
    #2; void'(exp_q.pop_front());
    @(posedge clk); #1; f = flag_q.pop_front(); mflags = f; checks++;
    if ({z, n, v} !== 3'b001) begin errors++; $display("FAIL mid_setup_flags got %b want 001", {z, n, v}); end
    drive(16'hCC00, 16'h0040, 16'h0000, 16'h0000);
    #2; e = exp_q.pop_front(); checks++;
    if (observe() !== e) begin errors++; $display("FAIL bvs_before got %h want %h", observe(), e); end
    rst = 1'b1;
    #1; checks++;
    if ({z, n, v} !== 3'b000 || take_br !== 1'b0) begin
      errors++; $display("FAIL async_reset got flags=%b take=%b want 000 0", {z, n, v}, take_br);
    end
    void'(flag_q.pop_back());
    mflags = 3'b000;
    drive(16'h0123, 16'h0000, 16'h7FFF, 16'h0001);
    #1; e = exp_q.pop_front(); checks++;
    if (observe() !== e) begin errors++; $display("FAIL add_in_reset got %h want %h", observe(), e); end
    @(posedge clk); #1; f = flag_q.pop_front(); mflags = f; checks++;
    if ({z, n, v} !== 3'b000) begin errors++; $display("FAIL reset_discard got %b want 000", {z, n, v}); end
    rst = 1'b0;
    drive(16'hCC00, 16'h0040, 16'h0000, 16'h0000);
    #2; e = exp_q.pop_front(); checks++;
    if (observe() !== e || take_br !== 1'b0) begin errors++; $display("FAIL bvs_after_reset got %h want %h", observe(), e); end
    @(posedge clk); #1; f = flag_q.pop_front(); mflags = f;
    drive(16'h0123, 16'h0000, 16'h7FFF, 16'h0001);
    #2; void'(exp_q.pop_front());
    @(posedge clk); #1; f = flag_q.pop_front(); mflags = f; checks++;
    if ({z, n, v} !== 3'b001) begin errors++; $display("FAIL post_release_flags got %b want 001", {z, n, v}); end
  endtask

  task automatic test_random();
    comb_t e;
    logic [2:0] f;
    for (int k = 0; k < 300; k++) begin
      drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      #2; e = exp_q.pop_front(); checks++;
      if (observe() !== e) begin
        errors++; $display("FAIL random[%0d] instr=%h got %h want %h", k, instr, observe(), e);
      end
      @(posedge clk); #1; f = flag_q.pop_front(); mflags = f; checks++;
      if ({z, n, v} !== f) begin errors++; $display("FAIL random_flags[%0d] got %b want %b", k, {z, n, v}, f); end
    end
  endtask

  initial begin
    rst = 1'b1; instr = '0; pc = '0; op_a = '0; op_b = '0; mflags = 3'b000;
    test_reset();
    test_add_sub_sat();
    test_sub_branch();
    test_ops();
    test_call_ret();
    test_branch_conds();
    test_halt();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
